// File: rtl/ps2_rx_frontend.sv
// ps2_rx_frontend
//   PS/2 device-to-host receiver. Synchronises and deglitches the raw
//   ps2clk/ps2dat pins, deserialises 11-bit frames (start, 8 data LSB first,
//   odd parity, stop) and presents each scan code on a valid/ready holding
//   register. Single clock domain.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   ps2clk      raw PS/2 clock pin (asynchronous)
//   ps2dat      raw PS/2 data pin (asynchronous)
//   data        received byte, stable while data_valid=1
//   data_valid  data holds an unconsumed byte
//   data_ready  consumer takes data this cycle when data_valid=1
//   parity_err  1-cycle pulse: frame dropped on parity mismatch
//   frame_err   1-cycle pulse: bad start, bad stop or inter-edge timeout
//   overrun     1-cycle pulse: finished byte dropped, holding register full
//   busy        receive FSM not idle
module ps2_rx_frontend #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2clk,
    input  logic       ps2dat,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ---------------- synchronisers (idle-high bus) ----------------
    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // ---------------- deglitch filters ----------------
    // The filtered level flips on the FILTER_LEN-th consecutive sample that
    // disagrees with it; any agreeing sample restarts the count.
    logic           clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
    logic [FCW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
    logic           fall_q;

    always_comb begin
        clk_filt_d = clk_filt_q;
        clk_cnt_d  = '0;
        if (clk_s2_q != clk_filt_q) begin
            if (clk_cnt_q == FCW'(FILTER_LEN - 1)) clk_filt_d = clk_s2_q;
            else                                   clk_cnt_d  = clk_cnt_q + FCW'(1);
        end
    end

    always_comb begin
        dat_filt_d = dat_filt_q;
        dat_cnt_d  = '0;
        if (dat_s2_q != dat_filt_q) begin
            if (dat_cnt_q == FCW'(FILTER_LEN - 1)) dat_filt_d = dat_s2_q;
            else                                   dat_cnt_d  = dat_cnt_q + FCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt_q <= 1'b1;
            clk_cnt_q  <= '0;
            dat_filt_q <= 1'b1;
            dat_cnt_q  <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_filt_q <= clk_filt_d;
            clk_cnt_q  <= clk_cnt_d;
            dat_filt_q <= dat_filt_d;
            dat_cnt_q  <= dat_cnt_d;
            // strobe aligns with the cycle the filtered clock is first low
            fall_q     <= clk_filt_q & ~clk_filt_d;
        end
    end

    // ---------------- frame FSM + holding register ----------------
    state_t         state_q;
    logic [2:0]     bitcnt_q;
    logic [7:0]     shift_q;
    logic           par_q;
    logic [TCW-1:0] to_cnt_q;
    logic [7:0]     data_q;
    logic           data_valid_q, parity_err_q, frame_err_q, overrun_q, busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;

            // plain consume; a delivery in the same cycle overrides below
            if (data_valid_q && data_ready) data_valid_q <= 1'b0;

            if (fall_q || state_q == IDLE) to_cnt_q <= '0;
            else                           to_cnt_q <= to_cnt_q + TCW'(1);

            // a falling edge in the timeout cycle keeps the frame alive
            if (state_q != IDLE && !fall_q && to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                frame_err_q <= 1'b1;
            end else if (fall_q) begin
                case (state_q)
                    IDLE: begin
                        if (!dat_filt_q) begin
                            state_q  <= DATA;
                            bitcnt_q <= '0;
                            busy_q   <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q  <= {dat_filt_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= dat_filt_q;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!dat_filt_q) begin
                            frame_err_q <= 1'b1;
                        end else if (!(^{shift_q, par_q})) begin
                            parity_err_q <= 1'b1;
                        end else if (!data_valid_q || data_ready) begin
                            data_q       <= shift_q;
                            data_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_rx_frontend.sv
module tb_ps2_rx_frontend;

    localparam int H = 40;  // clk cycles per PS/2 clock half period

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2dat = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data;
    logic       data_valid, parity_err, frame_err, overrun, busy;

    ps2_rx_frontend dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2clk     (ps2clk),
        .ps2dat     (ps2dat),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int np = 0, nf = 0, no = 0;

    always @(negedge clk) begin
        if (parity_err) np <= np + 1;
        if (frame_err)  nf <= nf + 1;
        if (overrun)    no <= no + 1;
    end

    typedef struct {
        logic [7:0] b;
        logic       par;
        logic       stop;
        logic       rdy;      // data_ready in the delivery cycle
        logic       consume;  // hold then consume afterwards
        logic       pv;       // data_valid just before delivery
        logic       ev;
        logic [7:0] ed;
        int         ep, ef, eo;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_cycle(input logic d);
        ps2dat = d;
        wait_clks(H);
        ps2clk = 1'b0;
        wait_clks(H);
        ps2clk = 1'b1;
    endtask

    task automatic run_frame(input int id, input vec_t v);
        logic [10:0] f;
        int p0, f0, o0;
        f = {v.stop, v.par, v.b, 1'b0};
        for (int i = 0; i < 10; i++) bit_cycle(f[i]);
        ps2dat = v.stop;
        wait_clks(H);
        p0 = np; f0 = nf; o0 = no;
        ps2clk = 1'b0;
        // fall strobe 10 edges after the raw edge, data_valid one edge later
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d valid_before", id), 32'(data_valid), 32'(v.pv));
        if (v.rdy) data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_ready = 1'b0;
        chk($sformatf("v%0d valid", id), 32'(data_valid), 32'(v.ev));
        chk($sformatf("v%0d data", id), 32'(data), 32'(v.ed));
        wait_clks(H);
        ps2clk = 1'b1;
        ps2dat = 1'b1;
        wait_clks(2 * H);
        chk($sformatf("v%0d parity_err", id), 32'(np - p0), 32'(v.ep));
        chk($sformatf("v%0d frame_err", id), 32'(nf - f0), 32'(v.ef));
        chk($sformatf("v%0d overrun", id), 32'(no - o0), 32'(v.eo));
        chk($sformatf("v%0d busy_after", id), 32'(busy), 32'd0);
        if (v.consume) begin
            wait_clks(20);
            chk($sformatf("v%0d hold", id), 32'(data_valid), 32'd1);
            @(negedge clk);
            data_ready = 1'b1;
            @(negedge clk);
            data_ready = 1'b0;
            chk($sformatf("v%0d consumed", id), 32'(data_valid), 32'd0);
        end
    endtask

    initial begin
        int f0;
        logic busy_seen;
        vec_t v;

        //            b      par   stop  rdy   cons  pv    ev    ed     ep ef eo
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 0, 0, 0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 1, 0, 0};
        vecs[2] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 0, 0, 0};
        vecs[3] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 0, 0, 1};
        vecs[4] = '{8'h2A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h2A, 0, 0, 0};
        vecs[5] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A, 0, 1, 0};

        // reset state
        wait_clks(3);
        chk("reset_outputs", {22'd0, data, data_valid, parity_err, frame_err, overrun, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_clks(5);

        for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

        // short glitch on the clock line is swallowed
        f0 = nf;
        busy_seen = 1'b0;
        ps2clk = 1'b0;
        wait_clks(3);
        ps2clk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        chk("glitch_busy", 32'(busy_seen), 32'd0);
        chk("glitch_frame_err", 32'(nf - f0), 32'd0);

        // long enough low with data high: bad start bit
        wait_clks(1);
        f0 = nf;
        busy_seen = 1'b0;
        ps2clk = 1'b0;
        wait_clks(10);
        ps2clk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        chk("badstart_busy", 32'(busy_seen), 32'd0);
        chk("badstart_frame_err", 32'(nf - f0), 32'd1);
        chk("badstart_valid", 32'(data_valid), 32'd0);

        // timeout: start + 4 data bits then silence
        wait_clks(H);
        f0 = nf;
        bit_cycle(1'b0);
        for (int i = 0; i < 4; i++) bit_cycle(i[0]);
        ps2dat = 1'b1;
        wait_clks(45000);
        chk("timeout_early_busy", 32'(busy), 32'd1);
        chk("timeout_early_ferr", 32'(nf - f0), 32'd0);
        wait_clks(5200);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_ferr", 32'(nf - f0), 32'd1);
        v = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 0, 0, 0};
        run_frame(6, v);

        // asynchronous reset mid-frame with a byte still held
        bit_cycle(1'b0);
        for (int i = 0; i < 5; i++) bit_cycle(1'b1);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        chk("pre_reset_valid", 32'(data_valid), 32'd1);
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {22'd0, data, data_valid, parity_err, frame_err, overrun, busy}, 32'd0);
        ps2clk = 1'b1;
        ps2dat = 1'b1;
        wait_clks(3);
        @(negedge clk);
        reset_n = 1'b1;
        wait_clks(5);
        v = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 0, 0, 0};
        run_frame(7, v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
